hex_display_ctrl: RTL and testbench
===================================

HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 SHALL have parameter BLANK_LZ, default 1, meaning that leading-zero blanking is enabled in decimal mode.
REQ-002 SHALL have parameter ACTIVE_LOW, default 1, meaning segment outputs are inverted, so 0 lights a segment.
REQ-003 SHALL have port clk_clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a display request is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port in_value, input, 24 bits: the value to display.
REQ-008 SHALL have port in_hex, input, 1 bit: 1 = hex mode (six nibbles), 0 = decimal mode.
REQ-009 SHALL have port in_dp, input, 6 bits: per-digit decimal point; bit i drives digit i.
REQ-010 SHALL have port hex3_hex0, output, 32 bits: digits 3..0, 8 bits each, with digit 0 in [7:0].
REQ-011 SHALL have port hex5_hex4, output, 16 bits: digit 5 in [15:8] and digit 4 in [7:0].
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when new segment values appear.

Function
REQ-013 SHALL use per-digit bit map: bit0..6 = segments a..g, bit7 = dp; active-high glyphs are then inverted when ACTIVE_LOW=1.
REQ-014 SHALL accept a request only on an edge where in_valid=1 and in_ready=1, latching in_value, in_hex and in_dp at that edge (T0).
REQ-015 SHALL hold in_ready=1 only in state IDLE; requests presented while not IDLE are ignored, with no queueing.
REQ-016 SHALL use FSM states IDLE, SHIFT and ENCODE; reset state is IDLE.
REQ-017 SHALL, on acceptance with in_hex=1 or decimal overflow, go IDLE->ENCODE; otherwise go IDLE->SHIFT.
REQ-018 SHALL, in SHIFT, perform exactly 20 double-dabble iterations on in_value[19:0], one per cycle (add 3 to any BCD nibble >=5, then shift left 1), then go to ENCODE.
REQ-019 SHALL, in ENCODE, register both output buses and assert done for exactly that cycle's edge, then return to IDLE.
REQ-020 SHALL have latency, from acceptance edge T0 to output update: hex mode or overflow at T1; decimal at T21 (1 + 20 + 1 edges); in_ready=1 again in the cycle after the update.
REQ-021 SHALL treat decimal overflow as in_value > 999999: all six digits show glyph '-' (segment g only); the dp bits are still applied.
REQ-022 SHALL use hex glyphs 0-9 and A, b, C, d, E, F (active-high: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71).
REQ-023 SHALL apply leading-zero blanking only in decimal mode with BLANK_LZ=1: each zero digit from 5 down to 1 is blanked until the first nonzero digit; digit 0 is never blanked; dp is unaffected by blanking.
REQ-024 SHALL hold outputs stable between updates; done=0 except in the ENCODE cycle.
REQ-025 SHALL not blank digits in hex mode.

Reset
REQ-026 SHALL, while reset_reset_n=0, asynchronously force: state IDLE, in_ready=1, done=0, all segments and dps off (ACTIVE_LOW=1: hex3_hex0=32'hFFFFFFFF, hex5_hex4=16'hFFFF).
REQ-027 SHALL, on reset mid-SHIFT or mid-ENCODE, abort the conversion; no done pulse and no partial output are produced.
REQ-028 SHALL accept a request on the first rising edge after reset deasserts.

Verification (ACTIVE_LOW=1, BLANK_LZ=1, in_dp=0)
REQ-029 SHALL cover: decimal 123456 -> at T21 hex5_hex4=16'hF9A4, hex3_hex0=32'hB0999282, done high 1 cycle, in_ready low for T1..T21.
REQ-030 SHALL cover: decimal 42, then decimal 0 -> hex5_hex4=16'hFFFF, hex3_hex0=32'hFFFF99A4; then hex3_hex0=32'hFFFFFFC0.
REQ-031 SHALL cover: hex 24'hABCDEF -> at T1 hex5_hex4=16'h8883, hex3_hex0=32'hC6A1868E; hex 0 -> all digits 8'hC0.
REQ-032 SHALL cover: decimal 1000000 -> at T1 all digits 8'hBF; decimal 999999 -> all digits 8'h90 at T21.
REQ-033 SHALL cover: in_valid held during a conversion -> the second value is accepted only after done; reset asserted at T10 -> outputs all-FF immediately, no done pulse.
REQ-034 SHALL cover: in_dp=6'b000001 with decimal 5 -> hex3_hex0=32'hFFFFFF12.

Source files
------------

// File: rtl/hex_display_ctrl.sv
// Six-digit seven-segment display controller.
// A request carries a 24-bit value, a mode bit (hex or decimal) and six
// decimal-point bits. Hex values and decimal overflows are encoded one
// cycle after acceptance. Other decimal values first pass through a
// 20-iteration double-dabble BCD conversion.
//
// Handshake: a request transfers on a rising edge where in_valid and in_ready
// are both 1. in_ready is high only while IDLE. A request that is presented
// while busy is not queued, and in_valid may stay high until it is taken.
// Both segment buses update together on the ENCODE edge. done is high for
// the one cycle that follows that edge.
module hex_display_ctrl #(
    parameter bit BLANK_LZ   = 1'b1,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_value,
    input  logic        in_hex,
    input  logic [5:0]  in_dp,
    output logic [31:0] hex3_hex0,
    output logic [15:0] hex5_hex4,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ENCODE = 2'd2
    } state_t;

    // state is kept as a named enum so checkers can bind to it hierarchically
    state_t      state;
    state_t      state_nxt;

    logic [23:0] bcd;        // BCD digits (decimal) or raw nibbles (hex)
    logic [19:0] bin;        // binary bits still to be shifted into bcd
    logic [23:0] bcd_adj;
    logic [4:0]  iter_cnt;
    logic        mode_hex;
    logic        ovf;
    logic [5:0]  dp_q;
    logic        accept;
    logic        in_ovf;
    logic        seg_load;
    logic [47:0] seg_nxt;

    localparam logic [47:0] SEG_OFF = ACTIVE_LOW ? {48{1'b1}} : 48'h0;

    assign accept = in_valid & in_ready;
    assign in_ovf = (in_value > 24'd999999);

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    // State register; reset aborts any conversion in flight
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state <= IDLE;
        else                state <= state_nxt;
    end

    // Next-state logic: hex and overflow skip the BCD conversion
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = (in_hex || in_ovf) ? ENCODE : SHIFT;
            end
            SHIFT: begin
                if (iter_cnt == 5'd19) state_nxt = ENCODE;
            end
            ENCODE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: ready only when idle, segment load on the ENCODE edge
    always_comb begin
        in_ready = (state == IDLE);
        seg_load = (state == ENCODE);
    end

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 6; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Conversion datapath. In hex mode, bcd holds the value's nibbles directly
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bcd      <= '0;
            bin      <= '0;
            iter_cnt <= '0;
            mode_hex <= 1'b0;
            ovf      <= 1'b0;
            dp_q     <= '0;
        end else if (accept) begin
            bcd      <= in_hex ? in_value : 24'h0;
            bin      <= in_value[19:0];
            iter_cnt <= '0;
            mode_hex <= in_hex;
            ovf      <= !in_hex && in_ovf;
            dp_q     <= in_dp;
        end else if (state == SHIFT) begin
            {bcd, bin} <= {bcd_adj[22:0], bin, 1'b0};
            iter_cnt   <= iter_cnt + 5'd1;
        end
    end

    // Glyph selection, overflow dashes, leading-zero blanking and polarity
    always_comb begin : seg_build
        logic       lead;
        logic [3:0] d;
        logic [6:0] g;
        logic [7:0] b;
        seg_nxt = '0;
        lead    = 1'b1;
        d       = '0;
        g       = '0;
        b       = '0;
        for (int i = 5; i >= 0; i--) begin
            d = bcd[4*i +: 4];
            g = glyph(d);
            if (ovf) begin
                g = 7'h40;
            end else if (!mode_hex && BLANK_LZ && lead && (i != 0) && (d == 4'h0)) begin
                g = 7'h00;
            end
            if (d != 4'h0) lead = 1'b0;
            b = {dp_q[i], g};
            seg_nxt[8*i +: 8] = ACTIVE_LOW ? ~b : b;
        end
    end

    // Output registers: update and pulse done only on the ENCODE edge
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            hex3_hex0 <= SEG_OFF[31:0];
            hex5_hex4 <= SEG_OFF[47:32];
            done      <= 1'b0;
        end else begin
            done <= seg_load;
            if (seg_load) begin
                hex3_hex0 <= seg_nxt[31:0];
                hex5_hex4 <= seg_nxt[47:32];
            end
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Testbench for hex_display_ctrl with the default parameters
// (ACTIVE_LOW=1, BLANK_LZ=1). A driver pushes the expected display and the
// expected completion cycle for each accepted request. A monitor pops these
// on every done pulse and checks the buses and the timing.
module tb_hex_display_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_value;
    logic        in_hex;
    logic [5:0]  in_dp;
    logic [31:0] hex3_hex0;
    logic [15:0] hex5_hex4;
    logic        done;

    logic [47:0] exp_q[$];
    int          lat_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;

    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    hex_display_ctrl dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_value      (in_value),
        .in_hex        (in_hex),
        .in_dp         (in_dp),
        .hex3_hex0     (hex3_hex0),
        .hex5_hex4     (hex5_hex4),
        .done          (done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Returns {hex5_hex4, hex3_hex0}. Decimal digits come from division.
    // Blanking covers every digit position above the most significant
    // nonzero digit.
    function automatic logic [47:0] model(input logic [23:0] v, input logic h, input logic [5:0] dp);
        logic [47:0] r = '0;
        int unsigned val = v;
        int unsigned pw = 1;
        int          n = 1;
        int unsigned d;
        logic [6:0]  g;
        for (int unsigned x = val / 10; x > 0; x = x / 10) n++;
        for (int i = 0; i < 6; i++) begin
            if (h) d = (val >> (4 * i)) & 15;
            else   d = (val / pw) % 10;
            pw = pw * 10;
            g = GLYPH[d[3:0]];
            if (!h && val > 999999) g = 7'h40;
            else if (!h && i >= n) g = 7'h00;
            r[8*i +: 8] = ~{dp[i], g};
        end
        return r;
    endfunction

    function automatic int latency(input logic [23:0] v, input logic h);
        return (h || v > 24'd999999) ? 1 : 21;
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic [23:0] v, input logic h, input logic [5:0] dp, output int acc);
        int waited = 0;
        acc = -1;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
            return;
        end
        in_valid = 1'b1;
        in_value = v;
        in_hex   = h;
        in_dp    = dp;
        @(posedge clk);
        #1;
        acc = cyc;
        exp_q.push_back(model(v, h, dp));
        lat_q.push_back(acc + latency(v, h));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0", exp_q.size());
            exp_q.delete();
            lat_q.delete();
        end
        #2;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [47:0] last_bus;
    logic        prev_done = 1'b0;
    always @(posedge clk) begin
        logic [47:0] bus;
        logic [47:0] e;
        int          l;
        #1;
        bus = {hex5_hex4, hex3_hex0};
        if (!rst_n) begin
            prev_done = 1'b0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL spurious_done: done=1 at cycle %0d, expected no result", cyc);
            end else begin
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                check("segments", bus, e);
                check("done_cycle", 48'(cyc), 48'(l));
            end
            check("done_width", {47'b0, prev_done}, 48'h0);
        end else begin
            check("hold_stable", bus, last_bus);
        end
        last_bus  = bus;
        prev_done = done;
    end

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        int acc2;
        int rel;
        logic [23:0] rv;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_value = '0;
        in_hex   = 1'b0;
        in_dp    = '0;
        #12;
        check("reset_bus", {hex5_hex4, hex3_hex0}, {48{1'b1}});
        check("reset_ready_done", {46'b0, in_ready, done}, 48'h2);

        // The first rising edge after reset is released must accept a request
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel = cyc;
        send(24'd123456, 1'b0, 6'd0, acc);
        check("accept_after_reset", 48'(acc), 48'(rel + 1));
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk);
            #1;
            check("ready_during_conv", {47'b0, in_ready}, {47'b0, (k == 21)});
        end
        drain();
        check("dec_123456", {hex5_hex4, hex3_hex0}, {16'hF9A4, 32'hB0999282});

        send(24'd42, 1'b0, 6'd0, acc);
        drain();
        check("dec_42", {hex5_hex4, hex3_hex0}, {16'hFFFF, 32'hFFFF99A4});
        send(24'd0, 1'b0, 6'd0, acc);
        drain();
        check("dec_0", {hex5_hex4, hex3_hex0}, {16'hFFFF, 32'hFFFFFFC0});
        send(24'hABCDEF, 1'b1, 6'd0, acc);
        drain();
        check("hex_abcdef", {hex5_hex4, hex3_hex0}, {16'h8883, 32'hC6A1868E});
        send(24'h0, 1'b1, 6'd0, acc);
        drain();
        check("hex_0", {hex5_hex4, hex3_hex0}, {6{8'hC0}});
        send(24'd1000000, 1'b0, 6'd0, acc);
        drain();
        check("dec_ovf", {hex5_hex4, hex3_hex0}, {6{8'hBF}});
        send(24'd999999, 1'b0, 6'd0, acc);
        drain();
        check("dec_999999", {hex5_hex4, hex3_hex0}, {6{8'h90}});
        send(24'd5, 1'b0, 6'b000001, acc);
        drain();
        check("dec_5_dp0", {hex5_hex4, hex3_hex0}, {16'hFFFF, 32'hFFFFFF12});

        // in_valid stays high; a new value must wait until the first result is done
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 24'd777;
        in_hex   = 1'b0;
        in_dp    = 6'd0;
        @(posedge clk);
        #1;
        acc = cyc;
        exp_q.push_back(model(24'd777, 1'b0, 6'd0));
        lat_q.push_back(acc + 21);
        in_value = 24'd31337;
        acc2 = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc2 = cyc;
                exp_q.push_back(model(24'd31337, 1'b0, 6'd0));
                lat_q.push_back(acc2 + 21);
                break;
            end
        end
        in_valid = 1'b0;
        check("held_valid_accept", 48'(acc2), 48'(acc + 22));
        drain();

        // Reset ten cycles into a conversion: outputs go dark at once, no done pulse
        send(24'd555555, 1'b0, 6'd0, acc);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_bus", {hex5_hex4, hex3_hex0}, {48{1'b1}});
        check("midreset_ready_done", {46'b0, in_ready, done}, 48'h2);
        exp_q.delete();
        lat_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel = cyc;
        repeat (25) @(posedge clk);
        #1;
        check("no_done_after_abort", {hex5_hex4, hex3_hex0}, {48{1'b1}});
        rel = cyc;
        send(24'd8, 1'b0, 6'd0, acc);
        check("accept_after_midreset", 48'(acc), 48'(rel + 1));
        drain();

        // Randomized requests
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0:       rv = 24'($urandom_range(0, 999));
                1:       rv = 24'($urandom_range(0, 999999));
                2:       rv = 24'($urandom_range(1000000, 24'hFFFFFF));
                default: rv = 24'($urandom);
            endcase
            send(rv, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), acc);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
